// File: rtl/axi_lite_read_slave_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_read_slave_ctrl_if
//  Purpose  : AXI4-Lite read-address (AR) and read-data (R) channel bundle.
//  Signals  : ARADDR/ARVALID/ARREADY  - read address channel
//             RDATA/RRESP/RVALID/RREADY - read data channel
//  Modports : master (drives AR, accepts R), slave (accepts AR, drives R)
//  Revision : 1.0  initial release
// ============================================================================
interface axi_lite_read_slave_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output ARADDR, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  ARADDR, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RVALID
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_read_slave_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_read_slave_ctrl
//  Purpose  : AXI4-Lite slave read controller. Accepts one AR beat, decodes
//             it, strobes a single register-file read and returns RDATA/RRESP
//             on the R channel with a fixed latency.
//  Ports    : ACLK, ARESETn (async, active-low)
//             axi          - AR/R channels (slave modport)
//             reg_rd_en    - one-cycle register-file read strobe
//             reg_rd_idx   - word index of the read
//             reg_rd_data  - register data, sampled at the end of the strobe
//             reg_rd_err   - backend error, sampled with reg_rd_data
//  Options  : AR_SKID_EN - one-entry AR buffer so a second read can be
//             accepted while the first is in flight.
//  Revision : 1.0  initial release
// ============================================================================
module axi_lite_read_slave_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  wire logic                  ACLK,
  input  wire logic                  ARESETn,
  axi_lite_read_slave_ctrl_if.slave  axi,
  output logic                       reg_rd_en,
  output logic [IDX_W-1:0]           reg_rd_idx,
  input  wire logic [DATA_WIDTH-1:0] reg_rd_data,
  input  wire logic                  reg_rd_err
);

  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [1:0] c_RESP_DECERR = 2'b11;
  localparam logic [ADDR_WIDTH-1:0] c_NUM_WORDS = ADDR_WIDTH'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_live;      // low until the first edge after reset release
  logic [IDX_W-1:0]      r_idx;
  logic [1:0]            r_dec;       // decode result of the read in flight
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic                  w_arready;
  logic                  w_load_ar;   // load the current AR beat into the in-flight slot
  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic [1:0]            w_ar_dec;
  logic [IDX_W-1:0]      w_ar_idx;

`ifdef AR_SKID_EN
  logic                  r_skid_vld;
  logic [IDX_W-1:0]      r_skid_idx;
  logic [1:0]            r_skid_dec;
  logic                  w_skid_push;
  logic                  w_skid_pop;
`endif

  // Address decode: misalignment wins over range. The whole word address is
  // compared so high address bits never alias onto the register file.
  assign w_word_addr = axi.ARADDR >> 2;
  assign w_ar_idx    = axi.ARADDR[IDX_W+1:2];

  always_comb begin
    w_ar_dec = c_RESP_OKAY;
    if (axi.ARADDR[1:0] != 2'b00) begin
      w_ar_dec = c_RESP_SLVERR;
    end else if (w_word_addr >= c_NUM_WORDS) begin
      w_ar_dec = c_RESP_DECERR;
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arready   = 1'b0;
    w_load_ar   = 1'b0;
`ifdef AR_SKID_EN
    w_skid_push = 1'b0;
    w_skid_pop  = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_arready = r_live;
        if (axi.ARVALID && r_live) begin
          w_load_ar   = 1'b1;
          w_state_nxt = S_RD;
        end
      end
      S_RD: begin
`ifdef AR_SKID_EN
        w_arready   = !r_skid_vld;
        w_skid_push = axi.ARVALID && !r_skid_vld;
`endif
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
`ifdef AR_SKID_EN
        w_arready = !r_skid_vld;
        if (axi.RREADY) begin
          if (r_skid_vld) begin
            w_skid_pop  = 1'b1;
            w_state_nxt = S_RD;
          end else if (axi.ARVALID) begin
            // Buffer empty and a beat accepted on the same edge as the
            // response: it goes straight into the in-flight slot.
            w_load_ar   = 1'b1;
            w_state_nxt = S_RD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_skid_push = axi.ARVALID && !r_skid_vld;
        end
`else
        if (axi.RREADY) begin
          w_state_nxt = S_IDLE;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: in-flight slot and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_idx   <= '0;
      r_dec   <= c_RESP_OKAY;
      r_rdata <= '0;
      r_rresp <= c_RESP_OKAY;
    end else begin
      if (w_load_ar) begin
        r_idx <= w_ar_idx;
        r_dec <= w_ar_dec;
      end
`ifdef AR_SKID_EN
      else if (w_skid_pop) begin
        r_idx <= r_skid_idx;
        r_dec <= r_skid_dec;
      end
`endif
      // Response captured at the edge that ends the read cycle; an error of
      // either kind returns zero data.
      if (r_state == S_RD) begin
        if (r_dec != c_RESP_OKAY) begin
          r_rdata <= '0;
          r_rresp <= r_dec;
        end else if (reg_rd_err) begin
          r_rdata <= '0;
          r_rresp <= c_RESP_SLVERR;
        end else begin
          r_rdata <= reg_rd_data;
          r_rresp <= c_RESP_OKAY;
        end
      end
    end
  end

`ifdef AR_SKID_EN
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_skid_vld <= 1'b0;
      r_skid_idx <= '0;
      r_skid_dec <= c_RESP_OKAY;
    end else if (w_skid_push) begin
      r_skid_vld <= 1'b1;
      r_skid_idx <= w_ar_idx;
      r_skid_dec <= w_ar_dec;
    end else if (w_skid_pop) begin
      r_skid_vld <= 1'b0;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign axi.ARREADY = w_arready;
  assign axi.RVALID  = (r_state == S_RESP);
  assign axi.RDATA   = r_rdata;
  assign axi.RRESP   = r_rresp;
  assign reg_rd_en   = (r_state == S_RD) && (r_dec == c_RESP_OKAY);
  assign reg_rd_idx  = r_idx;

endmodule
`default_nettype wire
